// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   - receiver FSM state encoding
//   - frame length and the E0 / F0 prefix scan codes
//   - packed key-event record pushed into the event FIFO
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  localparam int PS2_EVT_W = $bits(ps2_evt_t);

  // Odd parity: data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_par_ok(input logic [8:0] data_par);
    return ^data_par;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: small synchronous first-word-fall-through FIFO.
//   dspclk, reset_n : clock, asynchronous active-low reset
//   push, din       : write request and data (ignored when full unless popping)
//   pop             : consume head entry (ignored when empty)
//   dout            : head entry, valid whenever !empty
//   full, empty     : occupancy flags
// A push and pop in the same cycle on a full FIFO both succeed.
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             dspclk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // When full, a simultaneous pop frees the slot the write lands in.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge dspclk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage is reset too so the head outputs read zero out of
      // reset; affordable here because the FIFO is only a few entries deep.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_decoder.sv
// ps2_rx_decoder: PS/2 keyboard receiver and scan-code decoder.
//   dspclk, reset_n  : system clock, asynchronous active-low reset
//   hid_clk, hid_dat : asynchronous PS/2 pins
//   rx_valid/rx_ready: valid/ready handshake for the head key event
//   rx_code, rx_ext, rx_brk : head event scan code, E0 and F0 prefix flags
//   par_err, frm_err, ovf   : one-cycle error pulses
//   err_cnt          : saturating count of all error pulses
//   busy             : a frame is being received
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int FILT_LEN   = 8,
  parameter int TIMEOUT    = 100000,
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic             dspclk,
  input  logic             reset_n,
  input  logic             hid_clk,
  input  logic             hid_dat,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_code,
  output logic             rx_ext,
  output logic             rx_brk,
  output logic             par_err,
  output logic             frm_err,
  output logic             ovf,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy
);

  localparam int FW    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  // Front end: synchroniser, clock glitch filter, falling-edge detect.
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall_evt;

  always_ff @(posedge dspclk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall_evt <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of
      // its predecessor, which is what turns this chain into a 2-flop synchroniser.
      clk_s1   <= hid_clk;
      clk_s2   <= clk_s1;
      dat_s1   <= hid_dat;
      dat_s2   <= dat_s1;
      fall_evt <= 1'b0;
      // Count consecutive samples disagreeing with the filtered level; the
      // level flips only after FILT_LEN of them in a row.
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FW'(FILT_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
          fall_evt <= filt_clk;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Frame FSM and decode.
  ps2_state_e     state;
  logic [9:0]     shreg;      // {stop, parity, data[7:0]} once the frame is in
  logic [3:0]     bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic           ext_flag, brk_flag;

  logic           fifo_full, fifo_empty, pop;
  ps2_evt_t       head, push_evt;

  logic           chk_frm, chk_par, good, is_ext, is_brk;
  logic           push_req, drop, tmo_hit, err_hit;

  assign pop = rx_valid && rx_ready;

  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path leaves a signal unassigned and infers a latch.
    chk_frm  = 1'b0;
    chk_par  = 1'b0;
    good     = 1'b0;
    if (state == ST_CHECK) begin
      chk_frm = !shreg[9];
      chk_par = shreg[9] && !odd_par_ok(shreg[8:0]);
      good    = shreg[9] && odd_par_ok(shreg[8:0]);
    end
    is_ext   = good && (shreg[7:0] == PS2_EXT);
    is_brk   = good && (shreg[7:0] == PS2_BRK);
    push_req = good && !is_ext && !is_brk;
    drop     = push_req && fifo_full && !pop;
    tmo_hit  = (state == ST_RECV) && !fall_evt && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    err_hit  = chk_frm || chk_par || drop || tmo_hit;
    push_evt = '{ext: ext_flag, brk: brk_flag, code: shreg[7:0]};
  end

  always_ff @(posedge dspclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      tmo_cnt  <= '0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      ovf      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      par_err <= chk_par;
      frm_err <= chk_frm || tmo_hit;
      ovf     <= drop;
      if (err_hit && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);

      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          // A high "start" bit is line noise or a lost frame tail: ignore it.
          if (fall_evt && !dat_s2) begin
            state   <= ST_RECV;
            bit_cnt <= 4'd1;
          end
        end
        ST_RECV: begin
          if (fall_evt) begin
            shreg   <= {dat_s2, shreg[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            tmo_cnt <= '0;
            if (bit_cnt == 4'(PS2_FRAME_BITS - 1)) state <= ST_CHECK;
          end else if (tmo_hit) begin
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          if (chk_frm || chk_par) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end else if (is_ext) begin
            ext_flag <= 1'b1;
          end else if (is_brk) begin
            brk_flag <= 1'b1;
          end else begin
            // Pushed or dropped, the prefixes belong to this code only.
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  ps2_evt_fifo #(
    .WIDTH (PS2_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .dspclk  (dspclk),
    .reset_n (reset_n),
    .push    (push_req),
    .din     (push_evt),
    .pop     (pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  assign rx_code  = head.code;
  assign rx_ext   = head.ext;
  assign rx_brk   = head.brk;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// tb_ps2_rx_decoder: directed scenarios for ps2_rx_decoder.
// dspclk is 1 MHz; the PS/2 device model clocks at 12.5 kHz (80 dspclk per bit).
`timescale 1ns/1ps
module tb_ps2_rx_decoder;

  localparam int TMO  = 500;
  localparam int HALF = 40;

  logic       dspclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       hid_clk = 1'b1;
  logic       hid_dat = 1'b1;
  logic       rx_ready = 1'b1;
  logic       rx_valid, rx_ext, rx_brk, par_err, frm_err, ovf, busy;
  logic [7:0] rx_code;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  // Observation state kept by the monitor.
  logic [9:0] ev_q[$];
  int par_n = 0, frm_n = 0, ovf_n = 0;
  int cyc = 0;
  int busy_fall_cyc = -1, valid_rise_cyc = -1;
  logic busy_prev = 1'b0, valid_prev = 1'b0;

  ps2_rx_decoder #(
    .FILT_LEN   (8),
    .TIMEOUT    (TMO),
    .FIFO_DEPTH (4),
    .ERR_W      (8)
  ) dut (
    .dspclk   (dspclk),
    .reset_n  (reset_n),
    .hid_clk  (hid_clk),
    .hid_dat  (hid_dat),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_code  (rx_code),
    .rx_ext   (rx_ext),
    .rx_brk   (rx_brk),
    .par_err  (par_err),
    .frm_err  (frm_err),
    .ovf      (ovf),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  always #500 dspclk = ~dspclk;

  always @(posedge dspclk) cyc++;

  always @(negedge dspclk) begin
    if (reset_n) begin
      if (rx_valid && rx_ready) ev_q.push_back({rx_ext, rx_brk, rx_code});
      if (par_err) par_n++;
      if (frm_err) frm_n++;
      if (ovf)     ovf_n++;
      if (busy_prev && !busy)     busy_fall_cyc  = cyc;
      if (!valid_prev && rx_valid) valid_rise_cyc = cyc;
    end
    busy_prev  = busy;
    valid_prev = rx_valid;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge dspclk);
    #1;
  endtask

  task automatic clear_obs();
    ev_q.delete();
    par_n = 0;
    frm_n = 0;
    ovf_n = 0;
  endtask

  // Device model: data changes mid-high, clock low for HALF cycles per bit.
  task automatic ps2_send(input logic [7:0] code, input logic par_flip,
                          input logic stop_bit, input int nbits);
    logic [10:0] fr;
    fr = {stop_bit, (~^code) ^ par_flip, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      hid_dat = fr[i];
      wait_cyc(HALF / 2);
      hid_clk = 1'b0;
      wait_cyc(HALF);
      hid_clk = 1'b1;
      wait_cyc(HALF / 2);
    end
    hid_dat = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cyc(3);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_code !== 8'h00) begin errors++; $display("FAIL reset_rx_code got=%h exp=00", rx_code); end
    checks++; if ({rx_ext, rx_brk} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {rx_ext, rx_brk}); end
    checks++; if ({par_err, frm_err, ovf} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {par_err, frm_err, ovf}); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_clean_frame();
    clear_obs();
    busy_fall_cyc  = -1;
    valid_rise_cyc = -1;
    rx_ready = 1'b1;
    ps2_send(8'h1C, 1'b0, 1'b1, 11);
    wait_cyc(20);
    checks++;
    if (valid_rise_cyc < 0 || valid_rise_cyc != busy_fall_cyc) begin
      errors++;
      $display("FAIL clean_latency valid_rise=%0d exp=%0d (cycle busy fell)", valid_rise_cyc, busy_fall_cyc);
    end
    checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL clean_count got=%0d exp=1", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== 10'h01C) begin errors++; $display("FAIL clean_event got=%h exp=01c", ev_q[0]); end
    end
    checks++; if (par_n + frm_n + ovf_n != 0) begin errors++; $display("FAIL clean_errs got=%0d exp=0", par_n + frm_n + ovf_n); end
  endtask

  task automatic test_prefixes();
    clear_obs();
    ps2_send(8'hF0, 1'b0, 1'b1, 11);
    ps2_send(8'h1C, 1'b0, 1'b1, 11);
    ps2_send(8'hE0, 1'b0, 1'b1, 11);
    ps2_send(8'hF0, 1'b0, 1'b1, 11);
    ps2_send(8'h75, 1'b0, 1'b1, 11);
    wait_cyc(20);
    checks++; if (ev_q.size() != 2) begin errors++; $display("FAIL prefix_count got=%0d exp=2", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== {2'b01, 8'h1C}) begin errors++; $display("FAIL prefix_ev0 got=%h exp=11c", ev_q[0]); end
      checks++; if (ev_q[1] !== {2'b11, 8'h75}) begin errors++; $display("FAIL prefix_ev1 got=%h exp=375", ev_q[1]); end
    end
    checks++; if (par_n + frm_n + ovf_n != 0) begin errors++; $display("FAIL prefix_errs got=%0d exp=0", par_n + frm_n + ovf_n); end
  endtask

  task automatic test_errors();
    clear_obs();
    ps2_send(8'h1C, 1'b1, 1'b1, 11);
    wait_cyc(10);
    checks++; if (par_n != 1) begin errors++; $display("FAIL par_err_pulses got=%0d exp=1", par_n); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL par_err_cnt got=%0d exp=1", err_cnt); end
    ps2_send(8'h32, 1'b0, 1'b0, 11);
    wait_cyc(10);
    checks++; if (frm_n != 1) begin errors++; $display("FAIL stop_frm_pulses got=%0d exp=1", frm_n); end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL stop_err_cnt got=%0d exp=2", err_cnt); end
    checks++; if (ev_q.size() != 0 || par_n != 1) begin errors++; $display("FAIL err_side_effects events=%0d par=%0d exp=0,1", ev_q.size(), par_n); end
  endtask

  task automatic test_timeout();
    clear_obs();
    ps2_send(8'h55, 1'b0, 1'b1, 6);
    wait_cyc(TMO + 10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    ps2_send(8'h32, 1'b0, 1'b1, 11);
    wait_cyc(20);
    checks++; if (frm_n != 1) begin errors++; $display("FAIL timeout_frm got=%0d exp=1", frm_n); end
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL timeout_err_cnt got=%0d exp=3", err_cnt); end
    checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL timeout_count got=%0d exp=1", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== 10'h032) begin errors++; $display("FAIL timeout_event got=%h exp=032", ev_q[0]); end
    end
  endtask

  task automatic test_overflow();
    clear_obs();
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) ps2_send(8'h15 + 8'(i), 1'b0, 1'b1, 11);
    wait_cyc(10);
    checks++; if (ovf_n != 1) begin errors++; $display("FAIL ovf_pulses got=%0d exp=1", ovf_n); end
    checks++; if (err_cnt !== 8'd4) begin errors++; $display("FAIL ovf_err_cnt got=%0d exp=4", err_cnt); end
    checks++; if (rx_valid !== 1'b1 || rx_code !== 8'h15) begin errors++; $display("FAIL ovf_head got=%b/%h exp=1/15", rx_valid, rx_code); end
    rx_ready = 1'b1;
    wait_cyc(10);
    checks++; if (ev_q.size() != 4) begin errors++; $display("FAIL drain_count got=%0d exp=4", ev_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ev_q[i] !== {2'b00, 8'h15 + 8'(i)}) begin
          errors++; $display("FAIL drain_ev%0d got=%h exp=%h", i, ev_q[i], {2'b00, 8'h15 + 8'(i)});
        end
      end
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", rx_valid); end
  endtask

  task automatic test_glitch_reset();
    clear_obs();
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hid_clk = 1'b0;
      wait_cyc(3);
      hid_clk = 1'b1;
      wait_cyc(30);
    end
    checks++; if (busy !== 1'b0 || par_n + frm_n != 0) begin errors++; $display("FAIL glitch_ignored busy=%b errs=%0d exp=0,0", busy, par_n + frm_n); end
    ps2_send(8'h1C, 1'b0, 1'b1, 4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got=%b exp=1", busy); end
    #123 reset_n = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL after_reset_busy got=%b exp=0", busy); end
    wait_cyc(TMO + 10);
    checks++;
    if (ev_q.size() != 0 || par_n + frm_n + ovf_n != 0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL after_reset_quiet events=%0d errs=%0d err_cnt=%0d exp=0,0,0", ev_q.size(), par_n + frm_n + ovf_n, err_cnt);
    end
    ps2_send(8'h1C, 1'b0, 1'b1, 11);
    wait_cyc(20);
    checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL recover_count got=%0d exp=1", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== 10'h01C) begin errors++; $display("FAIL recover_event got=%h exp=01c", ev_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_prefixes();
    test_errors();
    test_timeout();
    test_overflow();
    test_glitch_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
